// File: rtl/apb_master_arb.sv
// Two-requester APB master with round-robin arbitration and an ACCESS-phase timeout.
// Every output is a flop; the completing requester is masked during its done cycle.
module apb_master_arb #(
    parameter int TIMEOUT = 255
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        done0,
    output logic        done1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rdata,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic        PREADY,
    input  logic [31:0] PRDATA,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam logic [31:0] ABORT_DATA = 32'hDEADBEEF;
    localparam logic [7:0]  LAST_WAIT  = 8'(TIMEOUT - 1);

    state_t      state, state_n;
    logic [7:0]  wait_cnt, wait_cnt_n;
    logic        last, last_n;
    logic        gnt, gnt_n;
    logic        done0_n, done1_n, err0_n, err1_n;
    logic        psel_n, penable_n, pwrite_n;
    logic [31:0] paddr_n, pwdata_n, rdata_n;

    logic elig0, elig1, any_req, pick, timeout_hit;

    // done0/done1 are high only in the IDLE cycle after completion, so they double as masks
    assign elig0       = req0 & ~done0;
    assign elig1       = req1 & ~done1;
    assign any_req     = elig0 | elig1;
    assign pick        = (elig0 & elig1) ? ~last : elig1;
    assign timeout_hit = (wait_cnt == LAST_WAIT);
    assign state_dbg   = state;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
            last     <= 1'b1;
            gnt      <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            err0     <= 1'b0;
            err1     <= 1'b0;
            PSEL     <= 1'b0;
            PENABLE  <= 1'b0;
            PWRITE   <= 1'b0;
            PADDR    <= 32'd0;
            PWDATA   <= 32'd0;
            rdata    <= 32'd0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_cnt_n;
            last     <= last_n;
            gnt      <= gnt_n;
            done0    <= done0_n;
            done1    <= done1_n;
            err0     <= err0_n;
            err1     <= err1_n;
            PSEL     <= psel_n;
            PENABLE  <= penable_n;
            PWRITE   <= pwrite_n;
            PADDR    <= paddr_n;
            PWDATA   <= pwdata_n;
            rdata    <= rdata_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (any_req) state_n = SETUP;
            SETUP:   state_n = ACCESS;
            ACCESS:  if (PREADY || timeout_hit) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        wait_cnt_n = wait_cnt;
        last_n     = last;
        gnt_n      = gnt;
        done0_n    = 1'b0;
        done1_n    = 1'b0;
        err0_n     = 1'b0;
        err1_n     = 1'b0;
        pwrite_n   = PWRITE;
        paddr_n    = PADDR;
        pwdata_n   = PWDATA;
        rdata_n    = rdata;
        psel_n     = (state_n != IDLE);
        penable_n  = (state_n == ACCESS);
        case (state)
            IDLE: begin
                if (any_req) begin
                    gnt_n      = pick;
                    last_n     = pick;
                    wait_cnt_n = 8'd0;
                    pwrite_n   = pick ? we1    : we0;
                    paddr_n    = pick ? addr1  : addr0;
                    pwdata_n   = pick ? wdata1 : wdata0;
                end
            end
            ACCESS: begin
                if (PREADY) begin
                    if (!PWRITE) rdata_n = PRDATA;
                    done0_n = ~gnt;
                    done1_n = gnt;
                end else if (timeout_hit) begin
                    rdata_n = ABORT_DATA;
                    done0_n = ~gnt;
                    done1_n = gnt;
                    err0_n  = ~gnt;
                    err1_n  = gnt;
                end else begin
                    wait_cnt_n = wait_cnt + 8'd1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_apb_master_arb.sv
// Directed bench for apb_master_arb: single transfers, wait states, round-robin,
// timeout abort and mid-transfer reset; inputs change and outputs are sampled on negedge.
module tb_apb_master_arb;

    logic        PCLK, PRESETn;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        done0, done1, err0, err1;
    logic [31:0] rdata;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic [1:0]  state_dbg;

    int checks   = 0;
    int failures = 0;
    logic [0:0] exp_q[$];

    apb_master_arb #(.TIMEOUT(4)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .done0(done0), .done1(done1), .err0(err0), .err1(err1),
        .rdata(rdata), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA),
        .state_dbg(state_dbg)
    );

    // clock / reset
    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h, required %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge PCLK);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_psel"}, PSEL, 0);
        check({tag, "_pen"}, PENABLE, 0);
        check({tag, "_state"}, state_dbg, 0);
    endtask

    initial begin
        logic [0:0] who;
        PRESETn = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        PREADY = 0; PRDATA = 0;
        tick(); tick();

        // reset state
        check_idle("rst");
        check("rst_pwrite", PWRITE, 0);
        check("rst_paddr", PADDR, 0);
        check("rst_pwdata", PWDATA, 0);
        check("rst_rdata", rdata, 0);
        check("rst_done", {done1, done0, err1, err0}, 0);

        // write from requester 0, zero wait states, granted on first edge out of reset
        PRESETn = 1'b1;
        req0 = 1; we0 = 1; addr0 = 32'h10; wdata0 = 32'hA5A5A5A5; PREADY = 1;
        tick();
        check("wr_setup_sel", {PSEL, PENABLE}, 2'b10);
        check("wr_setup_state", state_dbg, 1);
        check("wr_setup_attr", {31'd0, PWRITE}, 1);
        check("wr_setup_addr", PADDR, 32'h10);
        check("wr_setup_wdata", PWDATA, 32'hA5A5A5A5);
        tick();
        check("wr_access_sel", {PSEL, PENABLE}, 2'b11);
        check("wr_access_addr", PADDR, 32'h10);
        check("wr_access_wdata", PWDATA, 32'hA5A5A5A5);
        check("wr_access_done", done0, 0);
        tick();
        check("wr_done0", done0, 1);
        check("wr_err0", err0, 0);
        check("wr_done1", done1, 0);
        check("wr_rdata_kept", rdata, 0);
        check_idle("wr_end");
        req0 = 0;
        tick();
        check("wr_done_pulse", done0, 0);

        // read from requester 1 with three wait states
        req1 = 1; we1 = 0; addr1 = 32'h4; wdata1 = 32'h0BADF00D;
        PREADY = 0; PRDATA = 32'h12345678;
        tick();
        check("rd_setup_sel", {PSEL, PENABLE}, 2'b10);
        check("rd_setup_addr", PADDR, 32'h4);
        check("rd_setup_pwrite", PWRITE, 0);
        check("rd_setup_pwdata", PWDATA, 32'h0BADF00D);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rd_wait_sel", {PSEL, PENABLE}, 2'b11);
            check("rd_wait_done", done1, 0);
        end
        tick();
        check("rd_last_access", {PSEL, PENABLE}, 2'b11);
        PREADY = 1;
        tick();
        check("rd_done1", done1, 1);
        check("rd_err1", err1, 0);
        check("rd_done0", done0, 0);
        check("rd_rdata", rdata, 32'h12345678);
        req1 = 0;
        tick();
        check("rd_done_pulse", done1, 0);

        // both requesters held: expect 0,1,0,1 with the finisher masked in its done cycle
        exp_q.push_back(1'b0); exp_q.push_back(1'b1);
        exp_q.push_back(1'b0); exp_q.push_back(1'b1);
        req0 = 1; we0 = 1; addr0 = 32'h100; wdata0 = 32'h11110000;
        req1 = 1; we1 = 0; addr1 = 32'h200; PRDATA = 32'h55AA55AA;
        tick();
        for (int k = 0; k < 4; k++) begin
            who = exp_q.pop_front();
            check("rr_setup_addr", PADDR, who ? 32'h200 : 32'h100);
            check("rr_setup_sel", {PSEL, PENABLE}, 2'b10);
            tick();
            check("rr_access_sel", {PSEL, PENABLE}, 2'b11);
            tick();
            check("rr_done", {done1, done0}, who ? 2'b10 : 2'b01);
            if (k == 3) begin
                check("rr_rdata", rdata, 32'h55AA55AA);
                req0 = 0; req1 = 0;
            end
            tick();
        end
        check_idle("rr_end");

        // timeout abort on a read from requester 0
        req0 = 1; we0 = 0; addr0 = 32'h300; PREADY = 0; PRDATA = 32'h0;
        tick();
        check("to_setup_addr", PADDR, 32'h300);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("to_access_sel", {PSEL, PENABLE}, 2'b11);
            check("to_access_done", done0, 0);
        end
        tick();
        check("to_done0", done0, 1);
        check("to_err0", err0, 1);
        check("to_rdata", rdata, 32'hDEADBEEF);
        check_idle("to_end");
        req0 = 0;
        tick();
        check("to_err_pulse", {done0, err0}, 0);

        // reset during ACCESS drops the transfer and restores the tie pointer
        req0 = 1; we0 = 1; addr0 = 32'h400; wdata0 = 32'hCAFE0000; PREADY = 0;
        tick();
        tick();
        check("rs_in_access", {PSEL, PENABLE}, 2'b11);
        #2 PRESETn = 1'b0;
        #1;
        check("rs_async_sel", {PSEL, PENABLE}, 0);
        check("rs_async_state", state_dbg, 0);
        check("rs_async_paddr", PADDR, 0);
        req0 = 0;
        tick();
        PRESETn = 1'b1;
        check("rs_no_done", {done1, done0}, 0);
        tick();
        check("rs_no_done2", {done1, done0}, 0);
        check_idle("rs_idle");

        req0 = 1; we0 = 1; addr0 = 32'h500; wdata0 = 32'h1;
        req1 = 1; we1 = 1; addr1 = 32'h600; wdata1 = 32'h2; PREADY = 1;
        tick();
        check("rs_tie_addr", PADDR, 32'h500);
        tick(); tick();
        check("rs_tie_done0", {done1, done0}, 2'b01);
        req0 = 0;
        tick();
        check("rs_next_addr", PADDR, 32'h600);
        check("rs_next_wdata", PWDATA, 32'h2);
        tick(); tick();
        check("rs_next_done1", {done1, done0}, 2'b10);
        req1 = 0;
        tick();
        check_idle("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_master_arb.md
APB_MASTER_ARB -- requirements
Module: apb_master_arb

Interface
REQ-001 Parameter TIMEOUT, default 255: max ACCESS-phase cycles before abort (range 1..255).
REQ-002 PCLK  input  1  sole clock; all state changes on rising edge.
REQ-003 PRESETn  input  1  reset, asynchronous, active-low.
REQ-004 req0, req1  input  1 each  transfer request from requester 0/1; level, held until done.
REQ-005 we0, we1  input  1 each  1=write, 0=read.
REQ-006 addr0, addr1  input  32 each  transfer address.
REQ-007 wdata0, wdata1  input  32 each  write data.
REQ-008 done0, done1  output  1 each  one-cycle completion pulse.
REQ-009 err0, err1  output  1 each  timeout flag, valid only with done.
REQ-010 rdata  output  32  read data, shared, valid with either done.
REQ-011 PSEL  output  1  transfer active (SETUP or ACCESS).
REQ-012 PENABLE  output  1  ACCESS phase.
REQ-013 PWRITE  output  1, PADDR  output  32, PWDATA  output  32  latched transfer attributes.
REQ-014 PREADY  input  1, PRDATA  input  32  from bus decoder (decoder returns PREADY=1, PRDATA=32'hDEADBEEF for unmapped addresses).

Function
REQ-015 All outputs SHALL be registered; FSM states IDLE, SETUP, ACCESS.
REQ-016 IDLE: if any unmasked req high, grant one, latch its we/addr/wdata into PWRITE/PADDR/PWDATA, next state SETUP; else stay IDLE.
REQ-017 Arbitration: round-robin; single requester always wins; both high -> requester not granted last; last-grant pointer resets to 1 (requester 0 wins first tie).
REQ-018 SETUP: PSEL=1, PENABLE=0, exactly one cycle, then ACCESS.
REQ-019 ACCESS: PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA stable for whole transfer.
REQ-020 ACCESS with PREADY=1 at edge: capture PRDATA into rdata (reads only; writes leave rdata unchanged), assert granted done for next cycle, err=0, PSEL=PENABLE=0, go IDLE.
REQ-021 ACCESS with PREADY=0: stay; wait counter increments, cleared on SETUP entry.
REQ-022 Counter reaching TIMEOUT with PREADY still 0: abort -> done=1, err=1, rdata=32'hDEADBEEF, PSEL=PENABLE=0, go IDLE.
REQ-023 done/err high exactly one cycle (the IDLE cycle after completion); in that cycle the just-completed requester's req SHALL be masked from arbitration; the other requester may be granted in that cycle.
REQ-024 Minimum transfer: grant cycle + SETUP + ACCESS = done 3 cycles after req first seen in IDLE with zero wait states.
REQ-025 req dropped mid-transfer: ignored, transfer completes and done still pulses.
REQ-026 Simultaneous done for one requester and new req of the other: handled per REQ-023, no idle bubble beyond it.
REQ-027 PWDATA SHALL be driven with latched wdata for reads as well (don't-care to slave, deterministic).

Reset
REQ-028 PRESETn low SHALL immediately force IDLE, PSEL=PENABLE=PWRITE=0, PADDR=PWDATA=rdata=0, done*/err*=0, counter=0, pointer=1, including mid-transfer; in-flight transfer is dropped without done.
REQ-029 First grant possible on the first rising edge after PRESETn deasserts.

Verification
REQ-030 req0 write addr0=0x00000010 wdata0=0xA5A5A5A5, PREADY=1 -> SETUP next cycle, ACCESS following, done0 3 cycles after req, err0=0, bus attributes stable.
REQ-031 req1 read addr1=0x00000004, PREADY low 3 ACCESS cycles, PRDATA=0x12345678 -> ACCESS lasts 4 cycles, rdata=0x12345678 with done1.
REQ-032 req0 and req1 raised same cycle, both held -> order 0,1,0,1; each done alternates; masked requester never regranted in its done cycle.
REQ-033 TIMEOUT=4, PREADY held 0 -> abort after 4 ACCESS cycles, done0=1, err0=1, rdata=0xDEADBEEF.
REQ-034 PRESETn pulsed low during ACCESS -> PSEL/PENABLE=0 immediately, no done pulse, next request starts cleanly with requester 0 winning a tie.
